i2s_rx_esp32: RTL

I2S_RX_ESP32 -- requirements
Module: i2s_rx_esp32

---
 rtl/i2s_pkg.sv | 11 +
 rtl/i2s_sync.sv | 35 +++
 rtl/i2s_rx_esp32.sv | 122 ++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared defaults and state encoding for the ESP32 I2S receiver.
package i2s_pkg;
   localparam int SAMPLE_W_DEF = 24;
   localparam int MIN_SLOT_DEF = 24;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      HOLD
   } state_t;
endpackage

// File: rtl/i2s_sync.sv
// Two-flop synchronizers for BCK/LRCK/DATA plus a one-cycle strobe on each
// synchronized BCK rising edge; LRCK and DATA come from the same stage as the strobe.
module i2s_sync (
   input  logic clk,
   input  logic rst,
   input  logic bck_pin,
   input  logic lrck_pin,
   input  logic data_pin,
   output logic strobe,
   output logic lrck,
   output logic data
);
   logic [1:0] bck_ff;
   logic [1:0] lrck_ff;
   logic [1:0] data_ff;
   logic       bck_dly;

   always_ff @(posedge clk) begin
      if (rst) begin
         bck_ff  <= '0;
         lrck_ff <= '0;
         data_ff <= '0;
         bck_dly <= 1'b0;
      end else begin
         bck_ff  <= {bck_ff[0], bck_pin};
         lrck_ff <= {lrck_ff[0], lrck_pin};
         data_ff <= {data_ff[0], data_pin};
         bck_dly <= bck_ff[1];
      end
   end

   assign strobe = bck_ff[1] & ~bck_dly;
   assign lrck   = lrck_ff[1];
   assign data   = data_ff[1];
endmodule

// File: rtl/i2s_rx_esp32.sv
// Standard-I2S receiver for an ESP32 master: captures SAMPLE_W MSB-first bits per
// slot, publishes L/R as a pair with a one-cycle valid, flags slots shorter than MIN_SLOT.
module i2s_rx_esp32
   import i2s_pkg::*;
#(
   parameter int SAMPLE_W = SAMPLE_W_DEF,
   parameter int MIN_SLOT = MIN_SLOT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                BCK_ESP32,
   input  logic                LRCK_ESP32,
   input  logic                DATA_ESP32,
   output logic [SAMPLE_W-1:0] SAMPLE_L,
   output logic [SAMPLE_W-1:0] SAMPLE_R,
   output logic                SAMPLE_VALID,
   output logic                FRAME_ERR
);
   localparam int            CW       = $clog2(MIN_SLOT + 1);
   localparam logic [CW-1:0] CNT_SAT  = CW'(MIN_SLOT);
   localparam logic [CW-1:0] CNT_FULL = CW'(SAMPLE_W);

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt, cnt_nxt, cnt_inc;
   logic [SAMPLE_W-1:0] shreg, shreg_nxt;
   logic [SAMPLE_W-1:0] hold_l, hold_l_nxt;
   logic [SAMPLE_W-1:0] shifted;
   logic                right, right_nxt;
   logic                lrck_prev;
   logic                strobe, lrck, data, lr_edge;
   logic                out_load, err_nxt;

   i2s_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .bck_pin  (BCK_ESP32),
      .lrck_pin (LRCK_ESP32),
      .data_pin (DATA_ESP32),
      .strobe   (strobe),
      .lrck     (lrck),
      .data     (data)
   );

   assign lr_edge = strobe & (lrck ^ lrck_prev);
   assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
   assign shifted = {shreg[SAMPLE_W-2:0], data};

   // The DATA bit seen on an LRCK-change strobe is still the last bit of the old
   // slot (one-bit I2S delay), so it is counted/shifted before the slot is judged.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      shreg_nxt  = shreg;
      hold_l_nxt = hold_l;
      right_nxt  = right;
      out_load   = 1'b0;
      err_nxt    = 1'b0;
      if (strobe) begin
         case (state)
            IDLE: begin
               if (lr_edge && !lrck) begin
                  state_nxt = SHIFT;
                  right_nxt = 1'b0;
                  cnt_nxt   = '0;
                  shreg_nxt = '0;
               end
            end
            SHIFT, HOLD: begin
               cnt_nxt = cnt_inc;
               if (state == SHIFT) begin
                  shreg_nxt = shifted;
                  if (cnt_inc == CNT_FULL) begin
                     state_nxt = HOLD;
                     if (right) out_load = 1'b1;
                     else       hold_l_nxt = shifted;
                  end
               end
               if (lr_edge) begin
                  cnt_nxt = '0;
                  if (cnt_inc < CNT_SAT) begin
                     err_nxt   = 1'b1;
                     out_load  = 1'b0;
                     state_nxt = IDLE;
                  end else begin
                     state_nxt = SHIFT;
                     right_nxt = lrck;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         shreg        <= '0;
         hold_l       <= '0;
         right        <= 1'b0;
         lrck_prev    <= 1'b0;
         SAMPLE_L     <= '0;
         SAMPLE_R     <= '0;
         SAMPLE_VALID <= 1'b0;
         FRAME_ERR    <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         shreg        <= shreg_nxt;
         hold_l       <= hold_l_nxt;
         right        <= right_nxt;
         SAMPLE_VALID <= out_load;
         FRAME_ERR    <= err_nxt;
         if (strobe) lrck_prev <= lrck;
         if (out_load) begin
            SAMPLE_L <= hold_l;
            SAMPLE_R <= shifted;
         end
      end
   end
endmodule
